// File: rtl/cdc_req_sender_pkg.sv
// Shared types and defaults for the 4-phase req/ack CDC sender.
// The optional handshake timeout is enabled with CDC_SENDER_TIMEOUT_EN.
package cdc_req_sender_pkg;

  typedef enum logic [1:0] {
    CDC_ST_IDLE = 2'd0,
    CDC_ST_REQ  = 2'd1,
    CDC_ST_REL  = 2'd2
  } cdc_state_e;

  localparam int CDC_CNT_W_DEF       = 4;
  localparam int CDC_ACK_TIMEOUT_DEF = 64;

endpackage

// File: rtl/cdc_req_sender_if.sv
// Event/handshake/status bundle of the CDC sender; master = sender side.
// Handshake: req_out rises to start a transfer, stays high until ack_sync=1, then stays low until ack_sync=0.
interface cdc_req_sender_if #(
  parameter int CNT_W = cdc_req_sender_pkg::CDC_CNT_W_DEF
);
  logic             evt_in;
  logic             ack_sync;
  logic             ovf_clr;
  logic             req_out;
  logic             busy;
  logic [CNT_W-1:0] pend_cnt;
  logic             ovf;
  logic             timeout_err;

  modport master (
    input  evt_in, ack_sync, ovf_clr,
    output req_out, busy, pend_cnt, ovf, timeout_err
  );

  modport slave (
    output evt_in, ack_sync, ovf_clr,
    input  req_out, busy, pend_cnt, ovf, timeout_err
  );
endinterface

// File: rtl/cdc_pend_cnt.sv
// Saturating up/down counter of queued events; clr has priority, inc+dec cancel.
module cdc_pend_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == {W{1'b1}});
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cdc_req_sender.sv
// Source-domain initiator of a 4-phase req/ack CDC handshake with an event queue.
// Define CDC_SENDER_TIMEOUT_EN to add the per-phase ack timeout and timeout_err.
module cdc_req_sender
  import cdc_req_sender_pkg::*;
#(
  parameter int CNT_W = CDC_CNT_W_DEF
`ifdef CDC_SENDER_TIMEOUT_EN
  , parameter int ACK_TIMEOUT = CDC_ACK_TIMEOUT_DEF
`endif
) (
  input  logic               clk_source,
  input  logic               rst_n,
  cdc_req_sender_if.master   bus,
  output cdc_state_e         state_dbg
);

  cdc_state_e       state_q, state_d;
  logic             req_out_q, req_out_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic             launch, inc, dec, drop, tmo, pend_nz, sat;
  logic [CNT_W-1:0] pend_cnt;

  assign pend_nz = (pend_cnt != '0);

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      CDC_ST_IDLE: begin
        // ack_sync in IDLE is a protocol error and deliberately ignored
        if (bus.evt_in || pend_nz) begin
          state_d = CDC_ST_REQ;
          launch  = 1'b1;
        end
      end
      CDC_ST_REQ: begin
        if (bus.ack_sync) state_d = CDC_ST_REL;
      end
      CDC_ST_REL: begin
        if (!bus.ack_sync) begin
          if (bus.evt_in || pend_nz) begin
            state_d = CDC_ST_REQ;
            launch  = 1'b1;
          end else begin
            state_d = CDC_ST_IDLE;
          end
        end
      end
      default: state_d = CDC_ST_IDLE;
    endcase
    if (tmo) begin
      state_d = CDC_ST_IDLE;
      launch  = 1'b0;
    end
    // A launch with an empty queue consumes the incoming event itself
    dec       = launch && pend_nz;
    inc       = bus.evt_in && !(launch && !pend_nz) && !tmo;
    drop      = bus.evt_in && !launch && sat && !tmo;
    req_out_d = (state_d == CDC_ST_REQ);
    busy_d    = (state_d != CDC_ST_IDLE);
    ovf_d     = drop ? 1'b1 : (bus.ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk_source or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CDC_ST_IDLE;
      req_out_q <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_out_q <= req_out_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  cdc_pend_cnt #(.W(CNT_W)) u_pend_cnt (
    .clk   (clk_source),
    .rst_n (rst_n),
    .clr   (tmo),
    .inc   (inc),
    .dec   (dec),
    .cnt   (pend_cnt),
    .sat   (sat)
  );

`ifdef CDC_SENDER_TIMEOUT_EN
  localparam int PH_W = $clog2(ACK_TIMEOUT + 1);

  logic [PH_W-1:0] phase_q, phase_d;
  logic            terr_q, terr_d;

  // Counter restarts on every state entry, so each phase gets the full budget
  assign tmo = (state_q != CDC_ST_IDLE) && (phase_q == PH_W'(ACK_TIMEOUT - 1));

  always_comb begin
    phase_d = phase_q;
    terr_d  = terr_q | tmo;
    if (state_d != state_q) begin
      phase_d = '0;
    end else if (state_q != CDC_ST_IDLE) begin
      phase_d = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk_source or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.timeout_err = terr_q;
`else
  assign tmo             = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.req_out  = req_out_q;
  assign bus.busy     = busy_q;
  assign bus.pend_cnt = pend_cnt;
  assign bus.ovf      = ovf_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_cdc_req_sender.sv
// Bench for cdc_req_sender: a CNT_W=4 and a CNT_W=2 instance share one stimulus
// stream and are each compared every cycle against an event-count reference model.
module tb_cdc_req_sender;
  import cdc_req_sender_pkg::*;

  logic       clk;
  logic       rst_n;
  cdc_state_e st_big, st_small;

  cdc_req_sender_if #(.CNT_W(4)) if_big ();
  cdc_req_sender_if #(.CNT_W(2)) if_small ();

  cdc_req_sender #(
    .CNT_W(4)
`ifdef CDC_SENDER_TIMEOUT_EN
    , .ACK_TIMEOUT(64)
`endif
  ) u_big (
    .clk_source (clk),
    .rst_n      (rst_n),
    .bus        (if_big),
    .state_dbg  (st_big)
  );

  cdc_req_sender #(
    .CNT_W(2)
`ifdef CDC_SENDER_TIMEOUT_EN
    , .ACK_TIMEOUT(8)
`endif
  ) u_small (
    .clk_source (clk),
    .rst_n      (rst_n),
    .bus        (if_small),
    .state_dbg  (st_small)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: index 0 = big, 1 = small
  bit m_active [2];  // a handshake is in progress
  bit m_req    [2];  // request level currently presented
  bit m_ovf    [2];
  bit m_terr   [2];
  int m_pend   [2];  // queued events not yet launched
  int m_age    [2];  // cycles spent in the current handshake phase
  int m_cap    [2] = '{15, 3};
  int m_tmo    [2] = '{64, 8};

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_req[i] = 0; m_ovf[i] = 0;
      m_terr[i] = 0; m_pend[i] = 0; m_age[i] = 0;
    end
  endfunction

  function automatic void model_step(int i, bit evt, bit ack, bit clr);
    bit drop;
    drop = 0;
`ifdef CDC_SENDER_TIMEOUT_EN
    if (m_active[i] && m_age[i] == m_tmo[i] - 1) begin
      m_active[i] = 0; m_req[i] = 0; m_pend[i] = 0; m_terr[i] = 1; m_age[i] = 0;
      if (clr) m_ovf[i] = 0;
      return;
    end
`endif
    if ((m_active[i] && m_req[i]) || (m_active[i] && ack)) begin
      // waiting for ack to rise, or for it to fall again: events are queued
      if (m_req[i] && ack) begin
        m_req[i] = 0;
        m_age[i] = 0;
      end else begin
        m_age[i]++;
      end
      if (evt) begin
        if (m_pend[i] < m_cap[i]) m_pend[i]++;
        else drop = 1;
      end
    end else begin
      // idle, or release just completed: start the oldest pending event if any
      m_age[i] = 0;
      if (m_pend[i] > 0) begin
        m_pend[i]--;
        if (evt) m_pend[i]++;
        m_active[i] = 1; m_req[i] = 1;
      end else if (evt) begin
        m_active[i] = 1; m_req[i] = 1;
      end else begin
        m_active[i] = 0; m_req[i] = 0;
      end
    end
    if (drop) m_ovf[i] = 1;
    else if (clr) m_ovf[i] = 0;
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("big.req_out",     {31'd0, if_big.req_out},     {31'd0, m_req[0]});
    check("big.busy",        {31'd0, if_big.busy},        {31'd0, m_active[0]});
    check("big.pend_cnt",    {28'd0, if_big.pend_cnt},    m_pend[0]);
    check("big.ovf",         {31'd0, if_big.ovf},         {31'd0, m_ovf[0]});
    check("big.timeout_err", {31'd0, if_big.timeout_err}, {31'd0, m_terr[0]});
    check("big.state_idle",  {31'd0, st_big == CDC_ST_IDLE}, {31'd0, !m_active[0]});
    check("small.req_out",     {31'd0, if_small.req_out},     {31'd0, m_req[1]});
    check("small.busy",        {31'd0, if_small.busy},        {31'd0, m_active[1]});
    check("small.pend_cnt",    {30'd0, if_small.pend_cnt},    m_pend[1]);
    check("small.ovf",         {31'd0, if_small.ovf},         {31'd0, m_ovf[1]});
    check("small.timeout_err", {31'd0, if_small.timeout_err}, {31'd0, m_terr[1]});
    check("small.state_idle",  {31'd0, st_small == CDC_ST_IDLE}, {31'd0, !m_active[1]});
  endtask

  // driver: apply inputs for one edge, then advance the model and compare
  task automatic step(input bit evt, input bit ack, input bit clr);
    if_big.evt_in   = evt; if_small.evt_in   = evt;
    if_big.ack_sync = ack; if_small.ack_sync = ack;
    if_big.ovf_clr  = clr; if_small.ovf_clr  = clr;
    @(posedge clk);
    #1;
    model_step(0, evt, ack, clr);
    model_step(1, evt, ack, clr);
    compare_all();
  endtask

  initial begin
    bit ack_r;
    rst_n = 1'b0;
    if_big.evt_in = 0; if_big.ack_sync = 0; if_big.ovf_clr = 0;
    if_small.evt_in = 0; if_small.ack_sync = 0; if_small.ovf_clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // single event: request one cycle later, full handshake back to idle
    step(1, 0, 0);
    check("single.req_rise", {31'd0, if_big.req_out}, 32'd1);
    step(0, 0, 0);
    step(0, 1, 0);
    check("single.req_fall", {31'd0, if_big.req_out}, 32'd0);
    step(0, 0, 0);
    check("single.idle", {31'd0, if_big.busy}, 32'd0);

    // three events queued during REQ, drained back-to-back
    step(1, 0, 0);
    repeat (3) step(1, 0, 0);
    check("queue.pend3", {28'd0, if_big.pend_cnt}, 32'd3);
    for (int k = 2; k >= 0; k--) begin
      step(0, 1, 0);
      step(0, 0, 0);
      check("queue.drain", {28'd0, if_big.pend_cnt}, k);
    end
    step(0, 1, 0);
    step(0, 0, 0);
    check("queue.idle", {31'd0, if_big.busy}, 32'd0);

    // saturation: small instance clips at 3, big later at 15
    step(1, 0, 0);
    repeat (5) step(1, 0, 0);
    check("sat.small_pend", {30'd0, if_small.pend_cnt}, 32'd3);
    check("sat.small_ovf",  {31'd0, if_small.ovf}, 32'd1);
    step(0, 0, 1);
    check("sat.small_clr", {31'd0, if_small.ovf}, 32'd0);
    check("sat.small_keep", {30'd0, if_small.pend_cnt}, 32'd3);
    repeat (12) step(1, 0, 0);
    check("sat.big_pend", {28'd0, if_big.pend_cnt}, 32'd15);
    check("sat.big_ovf",  {31'd0, if_big.ovf}, 32'd1);
    step(1, 0, 1);
    check("sat.set_wins", {31'd0, if_big.ovf}, 32'd1);
    repeat (18) begin
      step(0, 1, 0);
      step(0, 0, 0);
    end
    check("sat.drained", {31'd0, if_big.busy}, 32'd0);

    // event coinciding with a queued REL->REQ launch
    step(1, 0, 0);
    repeat (2) step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    check("coincide.pend", {28'd0, if_big.pend_cnt}, 32'd2);
    check("coincide.req",  {31'd0, if_big.req_out}, 32'd1);

    // asynchronous reset mid-handshake
    repeat (2) step(1, 0, 0);
    check("arst.pend_before", {28'd0, if_big.pend_cnt}, 32'd4);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.req",  {31'd0, if_big.req_out}, 32'd0);
    check("arst.pend", {28'd0, if_big.pend_cnt}, 32'd0);
    compare_all();
    if_big.evt_in = 0; if_small.evt_in = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0);

`ifdef CDC_SENDER_TIMEOUT_EN
    // ack stuck low: small instance gives up after 8 cycles in REQ
    step(1, 0, 0);
    repeat (7) step(0, 0, 0);
    check("tmo.still_req", {31'd0, if_small.req_out}, 32'd1);
    step(0, 0, 0);
    check("tmo.req",  {31'd0, if_small.req_out}, 32'd0);
    check("tmo.err",  {31'd0, if_small.timeout_err}, 32'd1);
    check("tmo.idle", {31'd0, if_small.busy}, 32'd0);
    step(0, 1, 0);
    step(0, 0, 0);
`endif

    // randomized traffic with a slowly toggling ack
    ack_r = 0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) ack_r = !ack_r;
      step($urandom_range(0, 2) == 0, ack_r, $urandom_range(0, 15) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
